// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and decodes per-cycle datapath strobes and mux selects from the current state.
module mc_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Retire,
    output logic       Illegal,
    output logic [3:0] StateDbg
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BRANCH   = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Where DECODE goes for an opcode this core does not implement.
    localparam state_t S_UNSUPPORTED = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] imm_dec;
    logic [2:0] funct_alu;

    // funct7b5 only selects sub for register-register ops; addi is always add.
    function automatic logic [2:0] funct_decode(input logic op5, input logic [2:0] f3,
                                                input logic f7b5);
        case (f3)
            3'b000:  funct_decode = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_decode = ALU_SLT;
            3'b110:  funct_decode = ALU_OR;
            3'b111:  funct_decode = ALU_AND;
            default: funct_decode = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_RST;
        case (state_reg)
            S_RST:      state_next = S_FETCH;
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = (funct3 == 3'b000 || funct3 == 3'b001)
                                                    ? S_BRANCH : S_UNSUPPORTED;
                    default:           state_next = S_UNSUPPORTED;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BRANCH:   state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_RST;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_dec = 2'b01;
            OP_BRANCH: imm_dec = 2'b10;
            OP_JAL:    imm_dec = 2'b11;
            default:   imm_dec = 2'b00;
        endcase
    end

    assign funct_alu = funct_decode(op[5], funct3, funct7b5);

    always_comb begin
        ImmSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        ALUControl = ALU_ADD;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Retire     = 1'b0;
        Illegal    = 1'b0;
        // The immediate select follows the opcode everywhere except the two idle states.
        if (state_reg != S_RST && state_reg != S_ILLEGAL) begin
            ImmSrc = imm_dec;
        end
        case (state_reg)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes bne from beq, inverting the taken sense.
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                Retire     = 1'b1;
                PCWrite    = Zero ^ funct3[0];
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
            end
            default: begin
                Illegal = 1'b0;
            end
        endcase
    end

    assign StateDbg = state_reg;

endmodule
